// File: rtl/flow_8to16.sv
// flow_8to16: packs an 8-bit valid/ready byte stream into a 16-bit valid/ready
// word stream, two bytes per word. LSB_FIRST selects where the first byte lands.
// Optional feature macro: FLOW_8TO16_FLUSH_EN adds src_last/dst_last and flushes a
// lone trailing byte as a word padded with PAD_BYTE.
module flow_8to16 #(
  parameter bit         LSB_FIRST = 1'b1,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_en,
  input  logic        src_val,
  output logic        src_rdy,
  input  logic [7:0]  src_data,
`ifdef FLOW_8TO16_FLUSH_EN
  input  logic        src_last,
  output logic        dst_last,
`endif
  output logic        dst_val,
  input  logic        dst_rdy,
  output logic [15:0] dst_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        dst_val_q, dst_val_d;
  logic [15:0] dst_data_q, dst_data_d;
`ifdef FLOW_8TO16_FLUSH_EN
  logic        dst_last_q, dst_last_d;
`endif

  logic out_free;
  logic src_acc;
  logic dst_acc;
  logic last_in;

  // Place the first and second byte of a word according to LSB_FIRST.
  function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
    pack = LSB_FIRST ? {second, first} : {first, second};
  endfunction

`ifdef FLOW_8TO16_FLUSH_EN
  assign last_in = src_last;
`else
  assign last_in = 1'b0;
`endif

  // Handshake qualifiers; a first byte is taken even while the output is stalled.
  always_comb begin
    out_free = ~dst_val_q | dst_rdy;
    src_rdy  = rst_n & cfg_en & (state_q != FLUSH) & ((state_q != HALF) | out_free);
    src_acc  = src_val & src_rdy;
    dst_acc  = dst_val_q & dst_rdy;
  end

  // Next-state logic: byte pairing, word load, padded flush and output drain.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dst_val_d  = dst_val_q;
    dst_data_d = dst_data_q;
`ifdef FLOW_8TO16_FLUSH_EN
    dst_last_d = dst_last_q;
`endif
    // Drain first; a load below in the same cycle overrides it and keeps valid high.
    if (dst_acc) begin
      dst_val_d = 1'b0;
    end
    case (state_q)
      EMPTY: begin
        if (src_acc) begin
          hold_d  = src_data;
          state_d = last_in ? FLUSH : HALF;
        end
      end
      HALF: begin
        if (src_acc) begin
          dst_data_d = pack(hold_q, src_data);
          dst_val_d  = 1'b1;
          state_d    = EMPTY;
`ifdef FLOW_8TO16_FLUSH_EN
          dst_last_d = last_in;
`endif
        end
      end
      FLUSH: begin
        if (out_free) begin
          dst_data_d = pack(hold_q, PAD_BYTE);
          dst_val_d  = 1'b1;
          state_d    = EMPTY;
`ifdef FLOW_8TO16_FLUSH_EN
          dst_last_d = 1'b1;
`endif
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset and disable both clear everything, dropping any partial byte.
  always_ff @(posedge clk) begin
    if (!rst_n || !cfg_en) begin
      state_q    <= EMPTY;
      hold_q     <= '0;
      dst_val_q  <= 1'b0;
      dst_data_q <= '0;
`ifdef FLOW_8TO16_FLUSH_EN
      dst_last_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      dst_val_q  <= dst_val_d;
      dst_data_q <= dst_data_d;
`ifdef FLOW_8TO16_FLUSH_EN
      dst_last_q <= dst_last_d;
`endif
    end
  end

  assign dst_val  = dst_val_q;
  assign dst_data = dst_data_q;
`ifdef FLOW_8TO16_FLUSH_EN
  assign dst_last = dst_last_q;
`endif

endmodule

// File: tb/tb_flow_8to16.sv
// Testbench for flow_8to16: directed vector table plus randomized traffic
// scored against a byte/word queue model. Two instances share all inputs:
// u_lsb (LSB_FIRST=1, PAD_BYTE=FF) and u_msb (LSB_FIRST=0, PAD_BYTE=FF).
module tb_flow_8to16;

  logic        clk = 1'b0;
  logic        rst_n, cfg_en, src_val, src_last, dst_rdy;
  logic [7:0]  src_data;
  logic        src_rdy_l, src_rdy_m, dst_val_l, dst_val_m;
  logic [15:0] dst_data_l, dst_data_m;
`ifdef FLOW_8TO16_FLUSH_EN
  logic        dst_last_l, dst_last_m;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flow_8to16 #(.LSB_FIRST(1'b1), .PAD_BYTE(8'hFF)) u_lsb (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .src_val(src_val), .src_rdy(src_rdy_l), .src_data(src_data),
`ifdef FLOW_8TO16_FLUSH_EN
    .src_last(src_last), .dst_last(dst_last_l),
`endif
    .dst_val(dst_val_l), .dst_rdy(dst_rdy), .dst_data(dst_data_l)
  );

  flow_8to16 #(.LSB_FIRST(1'b0), .PAD_BYTE(8'hFF)) u_msb (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .src_val(src_val), .src_rdy(src_rdy_m), .src_data(src_data),
`ifdef FLOW_8TO16_FLUSH_EN
    .src_last(src_last), .dst_last(dst_last_m),
`endif
    .dst_val(dst_val_m), .dst_rdy(dst_rdy), .dst_data(dst_data_m)
  );

  typedef struct {
    logic        rst_n, en, val;
    logic [7:0]  data;
    logic        last, drdy;
    logic        e_rdy, e_val;
    logic [15:0] e_data;   // expectation for the LSB_FIRST=1 instance
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic en, input logic v,
                              input logic [7:0] d, input logic l, input logic dr,
                              input logic er, input logic ev, input logic [15:0] ed,
                              input logic el);
    vec_t t;
    t.rst_n = r; t.en = en; t.val = v; t.data = d; t.last = l; t.drdy = dr;
    t.e_rdy = er; t.e_val = ev; t.e_data = ed; t.e_last = el;
    return t;
  endfunction

  function automatic logic [15:0] swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    rst_n = v.rst_n; cfg_en = v.en; src_val = v.val; src_data = v.data;
    src_last = v.last; dst_rdy = v.drdy;
    @(negedge clk);
    chk($sformatf("v%0d src_rdy_l", idx), {15'd0, src_rdy_l}, {15'd0, v.e_rdy});
    chk($sformatf("v%0d src_rdy_m", idx), {15'd0, src_rdy_m}, {15'd0, v.e_rdy});
    chk($sformatf("v%0d dst_val_l", idx), {15'd0, dst_val_l}, {15'd0, v.e_val});
    chk($sformatf("v%0d dst_val_m", idx), {15'd0, dst_val_m}, {15'd0, v.e_val});
    chk($sformatf("v%0d dst_data_l", idx), dst_data_l, v.e_data);
    chk($sformatf("v%0d dst_data_m", idx), dst_data_m, swap(v.e_data));
`ifdef FLOW_8TO16_FLUSH_EN
    chk($sformatf("v%0d dst_last_l", idx), {15'd0, dst_last_l}, {15'd0, v.e_last});
    chk($sformatf("v%0d dst_last_m", idx), {15'd0, dst_last_m}, {15'd0, v.e_last});
`endif
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  bbuf[$];
  logic [15:0] wq[$];
  logic        exp_rdy;

  initial begin
    rst_n = 1'b0; cfg_en = 1'b1; src_val = 1'b0; src_data = '0;
    src_last = 1'b0; dst_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //                r  en v  data   l  dr  erdy ev edata     el
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1,  0,   0, 16'h0000, 0)); // reset state
    // back-to-back stream
    vecs.push_back(mk(1, 1, 1, 8'h11, 0, 1,  1,   0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 1, 8'h22, 0, 1,  1,   0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 1, 8'h33, 0, 1,  1,   1, 16'h2211, 0));
    vecs.push_back(mk(1, 1, 1, 8'h44, 0, 1,  1,   0, 16'h2211, 0));
    vecs.push_back(mk(1, 1, 1, 8'hAB, 0, 1,  1,   1, 16'h4433, 0));
    vecs.push_back(mk(1, 1, 1, 8'hCD, 0, 1,  1,   0, 16'h4433, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   1, 16'hCDAB, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   0, 16'hCDAB, 0));
    // backpressure
    vecs.push_back(mk(1, 1, 1, 8'h11, 0, 0,  1,   0, 16'hCDAB, 0));
    vecs.push_back(mk(1, 1, 1, 8'h22, 0, 0,  1,   0, 16'hCDAB, 0));
    vecs.push_back(mk(1, 1, 1, 8'h33, 0, 0,  1,   1, 16'h2211, 0));
    vecs.push_back(mk(1, 1, 1, 8'h44, 0, 0,  0,   1, 16'h2211, 0));
    vecs.push_back(mk(1, 1, 1, 8'h44, 0, 0,  0,   1, 16'h2211, 0));
    vecs.push_back(mk(1, 1, 1, 8'h44, 0, 1,  1,   1, 16'h2211, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   1, 16'h4433, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   0, 16'h4433, 0));
    // cfg_en dropped after one byte
    vecs.push_back(mk(1, 1, 1, 8'h55, 0, 1,  1,   0, 16'h4433, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1,  0,   0, 16'h4433, 0));
    vecs.push_back(mk(1, 1, 1, 8'h01, 0, 1,  1,   0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 1, 8'h02, 0, 1,  1,   0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   1, 16'h0201, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   0, 16'h0201, 0));
    // reset mid-HALF with a stalled word
    vecs.push_back(mk(1, 1, 1, 8'h10, 0, 0,  1,   0, 16'h0201, 0));
    vecs.push_back(mk(1, 1, 1, 8'h20, 0, 0,  1,   0, 16'h0201, 0));
    vecs.push_back(mk(1, 1, 1, 8'h30, 0, 0,  1,   1, 16'h2010, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0,  0,   1, 16'h2010, 0));
    vecs.push_back(mk(1, 1, 1, 8'h40, 0, 1,  1,   0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 1, 8'h50, 0, 1,  1,   0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   1, 16'h5040, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   0, 16'h5040, 0));
`ifdef FLOW_8TO16_FLUSH_EN
    // lone last byte flushed with padding, then ordinary and last-in-HALF words
    vecs.push_back(mk(1, 1, 1, 8'h5A, 1, 1,  1,   0, 16'h5040, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  0,   0, 16'h5040, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   1, 16'hFF5A, 1));
    vecs.push_back(mk(1, 1, 1, 8'h61, 0, 1,  1,   0, 16'hFF5A, 1));
    vecs.push_back(mk(1, 1, 1, 8'h62, 0, 1,  1,   0, 16'hFF5A, 1));
    vecs.push_back(mk(1, 1, 1, 8'h71, 0, 1,  1,   1, 16'h6261, 0));
    vecs.push_back(mk(1, 1, 1, 8'h72, 1, 1,  1,   0, 16'h6261, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   1, 16'h7271, 1));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 1,  1,   0, 16'h7271, 1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Randomized traffic against a queue model: accepted bytes pair into words,
    // words are owed until handed over; output valid means a word is owed.
    rst_n = 1'b0; src_val = 1'b0; src_last = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      cfg_en   = 1'b1;
      src_last = 1'b0;
      src_val  = 1'($urandom_range(0, 1));
      src_data = 8'($urandom);
      dst_rdy  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = (bbuf.size() == 0) || (wq.size() == 0) || dst_rdy;
      chk($sformatf("r%0d src_rdy_l", c), {15'd0, src_rdy_l}, {15'd0, exp_rdy});
      chk($sformatf("r%0d src_rdy_m", c), {15'd0, src_rdy_m}, {15'd0, exp_rdy});
      chk($sformatf("r%0d dst_val_l", c), {15'd0, dst_val_l}, {15'd0, wq.size() != 0});
      chk($sformatf("r%0d dst_val_m", c), {15'd0, dst_val_m}, {15'd0, wq.size() != 0});
      if (dst_rdy && wq.size() != 0) begin
        chk($sformatf("r%0d word_l", c), dst_data_l, wq[0]);
        chk($sformatf("r%0d word_m", c), dst_data_m, swap(wq[0]));
        void'(wq.pop_front());
      end
      if (src_val && exp_rdy) begin
        bbuf.push_back(src_data);
        if (bbuf.size() == 2) begin
          wq.push_back({bbuf[1], bbuf[0]});
          bbuf.delete();
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
